uart_tx_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_ctrl.sv | 132 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding and default link parameters.
// The receiver is expected to import the same package.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_TICK_DIV   = 79;
  localparam int UART_DATA_BITS  = 8;

  function automatic int uart_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// 8N1 UART transmitter: accepts a byte on a valid/ready handshake and shifts it
// out LSB-first, each bit held for OVERSAMPLE baud ticks.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_TICKS = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(uart_max(OVERSAMPLE, STOP_TICKS));
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  uart_tx_state_t       state_q, state_d;
  logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Handshake: a byte transfers on any clk edge where tx_valid and tx_ready are
  // both high; tx_valid may rise at any time and need not wait for tx_ready.
  logic hs;
  assign tx_ready = (state_q == IDLE);
  assign hs       = tx_valid & tx_ready;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        tx_d       = 1'b1;
        if (hs) begin
          shift_d   = tx_data;
          bit_idx_d = '0;
          tx_d      = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            tx_d       = shift_q[0];
            state_d    = DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {1'b0, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == IDX_LAST) begin
              tx_d    = 1'b1;
              state_d = STOP;
            end else begin
              // Next line value is the bit that becomes shift[0] after this shift.
              tx_d      = shift_q[1];
              bit_idx_d = bit_idx_q + IDX_W'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == STOP_LAST) begin
            tick_cnt_d = '0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: random and directed frames, tick-level line model,
// scoreboard of accepted bytes popped on every tx_done.
module tb_uart_tx_ctrl;

  localparam int DB = 8;
  localparam int OS = 16;

  // clock / reset / tick
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  int   tick_div = 5;
  int   div_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (div_cnt >= tick_div - 1) begin
      tick = 1'b1;
      div_cnt = 0;
    end else begin
      tick = 1'b0;
      div_cnt++;
    end
  end

  // DUT with default stop length
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx, tx_busy, tx_done;

  uart_tx_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  // DUT with two stop bits
  logic [7:0] d32;
  logic       v32, r32, tx32, busy32, done32;

  uart_tx_ctrl #(.STOP_TICKS(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .tx_data(d32), .tx_valid(v32), .tx_ready(r32),
    .tx(tx32), .tx_busy(busy32), .tx_done(done32)
  );

  // scoreboard
  logic [DB-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int done_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  // reference line model: level expected during the k-th counted tick of a frame
  function automatic logic model_level(input logic [7:0] d, input int k);
    int b;
    b = k / OS;
    if (b == 0) return 1'b0;
    if (b <= DB) return d[b-1];
    return 1'b1;
  endfunction

  function automatic int model_len(input int stop_ticks);
    return (1 + DB) * OS + stop_ticks;
  endfunction

  // monitor
  logic lv_q[$];
  bit   collecting = 0;
  bit   prev_done = 0;
  int   frame_bad = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      collecting = 0;
      lv_q.delete();
      prev_done = 0;
    end else begin
      if (tx_done) begin
        logic [7:0] e;
        int mism;
        done_count++;
        chk("done_expected", (collecting && exp_q.size() > 0), 1);
        chk("done_single_cycle", prev_done, 0);
        if (collecting && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          mism = 0;
          for (int k = 0; k < lv_q.size(); k++)
            if (lv_q[k] !== model_level(e, k)) mism++;
          chk("frame_len_ticks", lv_q.size(), model_len(OS));
          chk("frame_bits", mism, 0);
          chk("in_frame_status", frame_bad, 0);
          chk("ready_at_done", tx_ready, 1);
          chk("busy_at_done", tx_busy, 0);
        end
        collecting = 0;
      end
      prev_done = tx_done;
      if (collecting && tick) begin
        lv_q.push_back(tx);
        if (tx_ready !== 1'b0 || tx_busy !== 1'b1 || tx_done !== 1'b0) frame_bad++;
      end
      if (tx_valid && tx_ready) begin
        collecting = 1;
        lv_q.delete();
        frame_bad = 0;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [7:0] d, input bit hold, output bit done_at_hs);
    bit ok;
    ok = 0;
    done_at_hs = 0;
    @(posedge clk); #2;
    tx_data = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        exp_q.push_back(d);
        done_at_hs = tx_done;
        ok = 1;
        break;
      end
    end
    chk("send_accepted", ok, 1);
    @(posedge clk); #2;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    bit ok;
    ok = 0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      if (tx_done) begin
        ok = 1;
        break;
      end
    end
    chk("done_within_budget", ok, 1);
  endtask

  task automatic wait_ticks(input int n);
    int seen;
    seen = 0;
    while (seen < n) begin
      @(negedge clk);
      if (tick) seen++;
    end
  endtask

  // watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    bit   ds;
    int   cyc, bad, nt, d0, n, mism;
    logic lv32[256];
    logic [7:0] rd;

    tx_valid = 1'b0;
    tx_data  = 8'h00;
    v32      = 1'b0;
    d32      = 8'h00;

    // reset and idle
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_tx32", tx32, 1);
    @(posedge clk); #2;
    rst_n = 1'b1;

    bad = 0;
    nt = 0;
    while (nt < 200) begin
      @(negedge clk);
      if (tick) nt++;
      if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    chk("idle_line", bad, 0);
    chk("idle_no_done", done_count, 0);

    // single byte at the real 79-clk tick rate
    tick_div = 79;
    send(8'hA5, 0, ds);
    wait_done(13000, cyc);
    chk("frame_clk_in_range", (cyc >= 12561 && cyc <= 12719), 1);
    tick_div = 5;

    // back-to-back with valid held high
    @(posedge clk);
    d0 = done_count;
    send(8'h00, 1, ds);
    send(8'hFF, 0, ds);
    chk("b2b_accept_on_done", ds, 1);
    wait_done(2000, cyc);
    @(posedge clk);
    chk("b2b_done_pulses", done_count - d0, 2);

    // tx_data changes mid-frame are ignored
    send(8'h3C, 0, ds);
    repeat (40) @(posedge clk);
    #2 tx_data = 8'hC3;
    wait_done(2000, cyc);

    // random frames with random gaps and input noise
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 30)) @(posedge clk);
      rd = 8'($urandom_range(0, 255));
      send(rd, 0, ds);
      repeat ($urandom_range(1, 300)) @(posedge clk);
      #2;
      tx_data  = 8'($urandom_range(0, 255));
      tx_valid = 1'b1;
      @(posedge clk); #2;
      tx_valid = 1'b0;
      wait_done(2000, cyc);
    end

    // reset during data bit 4 of 0x55
    send(8'h55, 0, ds);
    wait_ticks(88);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_ready", tx_ready, 1);
    chk("midrst_busy", tx_busy, 0);
    exp_q.delete();
    d0 = done_count;
    repeat (3) @(posedge clk);
    chk("midrst_no_done", done_count - d0, 0);
    #2 rst_n = 1'b1;
    send(8'h55, 0, ds);
    wait_done(2000, cyc);

    // two stop bits, handshake coincident with a tick
    ds = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (tick && r32) begin
        d32 = 8'($urandom_range(0, 255));
        v32 = 1'b1;
        ds = 1;
        break;
      end
    end
    chk("hs32_on_tick", ds, 1);
    @(posedge clk); #2;
    v32 = 1'b0;
    n = 0;
    ds = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done32) begin
        ds = 1;
        break;
      end
      if (tick && n < 256) begin
        lv32[n] = tx32;
        n++;
      end
    end
    chk("stop32_done_seen", ds, 1);
    chk("stop32_len_ticks", n, model_len(32));
    mism = 0;
    for (int k = 0; k < n; k++)
      if (lv32[k] !== ((k / OS) == 0 ? 1'b0 : ((k / OS) <= DB ? d32[(k / OS) - 1] : 1'b1)))
        mism++;
    chk("stop32_bits", mism, 0);

    @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("total_done_pulses", done_count, 9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
